// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with handshake timeouts.
// Optional `RETIRE_COUNT_EN adds a 64-bit retired-instruction counter on port instret.
module multicycle_control_fsm #(
    parameter int unsigned TIMEOUT_W   = 4,
    parameter int unsigned TIMEOUT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic        imem_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic [31:0] ir,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        dmem_req,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        instr_done,
    output logic        halted,
    output logic [1:0]  err_code,
    output logic [2:0]  state
`ifdef RETIRE_COUNT_EN
    ,
    output logic [63:0] instret
`endif
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_IMEM_TO = 2'd2;
    localparam logic [1:0] ERR_DMEM_TO = 2'd3;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = TIMEOUT_W'(TIMEOUT_MAX);

    state_t               state_q, state_d;
    logic [31:0]          ir_q, ir_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_sat;
    logic [1:0]           err_q, err_d;

    logic       imem_req_c, pc_write_c, alu_src_b_c, dmem_req_c;
    logic       mem_write_c, reg_write_c, instr_done_c;
    logic [1:0] pc_src_c, alu_op_c, wb_sel_c;

    // beq/bne only look at funct3[0]; upper bits are deliberately ignored
    logic unused_funct3;
    assign unused_funct3 = ^funct3[2:1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TIMEOUT_W'(1);

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        imem_req_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 2'd0;
        alu_src_b_c  = 1'b0;
        alu_op_c     = 2'd0;
        dmem_req_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        wb_sel_c     = 2'd0;
        instr_done_c = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_d       = instr_in;
                    pc_write_c = 1'b1;
                    pc_src_c   = 2'd0;
                    cnt_d      = '0;
                    state_d    = ST_DECODE;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = ERR_IMEM_TO;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_sat;
                end
            end

            ST_DECODE: begin
                case (opcode)
                    OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL:
                        state_d = ST_EXECUTE;
                    default: begin
                        err_d   = ERR_ILLEGAL;
                        state_d = ST_ERROR;
                    end
                endcase
            end

            ST_EXECUTE: begin
                case (opcode)
                    OP_R: begin
                        alu_src_b_c = 1'b0;
                        alu_op_c    = 2'd2;
                        state_d     = ST_WB;
                    end
                    OP_IALU: begin
                        alu_src_b_c = 1'b1;
                        alu_op_c    = 2'd2;
                        state_d     = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b_c = 1'b1;
                        alu_op_c    = 2'd0;
                        cnt_d       = '0;
                        state_d     = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op_c     = 2'd1;
                        pc_src_c     = 2'd1;
                        pc_write_c   = zero ^ funct3[0];
                        instr_done_c = 1'b1;
                        cnt_d        = '0;
                        state_d      = ST_FETCH;
                    end
                    OP_JAL: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = 2'd2;
                        state_d    = ST_WB;
                    end
                    // Parser output changed under a held ir: treat as illegal
                    default: begin
                        err_d   = ERR_ILLEGAL;
                        state_d = ST_ERROR;
                    end
                endcase
            end

            ST_MEM: begin
                dmem_req_c  = 1'b1;
                mem_write_c = (opcode == OP_STORE);
                if (dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        instr_done_c = 1'b1;
                        cnt_d        = '0;
                        state_d      = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = ERR_DMEM_TO;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_sat;
                end
            end

            ST_WB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                if (opcode == OP_LOAD) begin
                    wb_sel_c = 2'd1;
                end else if (opcode == OP_JAL) begin
                    wb_sel_c = 2'd2;
                end else begin
                    wb_sel_c = 2'd0;
                end
                cnt_d   = '0;
                state_d = ST_FETCH;
            end

            ST_ERROR: begin
                state_d = ST_ERROR;
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_FETCH;
            end
        endcase
    end

    // Strobes are forced low combinationally while reset is held
    always_comb begin
        imem_req   = reset & imem_req_c;
        pc_write   = reset & pc_write_c;
        pc_src     = reset ? pc_src_c : '0;
        alu_src_b  = reset & alu_src_b_c;
        alu_op     = reset ? alu_op_c : '0;
        dmem_req   = reset & dmem_req_c;
        mem_write  = reset & mem_write_c;
        reg_write  = reset & reg_write_c;
        wb_sel     = reset ? wb_sel_c : '0;
        instr_done = reset & instr_done_c;
    end

    assign ir       = ir_q;
    assign state    = state_q;
    assign err_code = err_q;
    assign halted   = (state_q == ST_ERROR);

`ifdef RETIRE_COUNT_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            instret_q <= '0;
        end else if (instr_done) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm; opcode/funct3 come from a parser model fed by ir.
// Define RETIRE_COUNT_EN to also exercise the instret counter.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_in;
    logic        imem_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        dmem_ready;
    logic        imem_req;
    logic [31:0] ir;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        dmem_req;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        instr_done;
    logic        halted;
    logic [1:0]  err_code;
    logic [2:0]  state;
`ifdef RETIRE_COUNT_EN
    logic [63:0] instret;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];

    multicycle_control_fsm #(
        .TIMEOUT_W   (4),
        .TIMEOUT_MAX (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_in   (instr_in),
        .imem_ready (imem_ready),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir         (ir),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .dmem_req   (dmem_req),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .wb_sel     (wb_sel),
        .instr_done (instr_done),
        .halted     (halted),
        .err_code   (err_code),
        .state      (state)
`ifdef RETIRE_COUNT_EN
        ,
        .instret    (instret)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        zero       = 1'b0;
        step();
        reset = 1'b1;
        #1;
    endtask

    // FETCH cycle with zero-wait imem, then the DECODE cycle; returns at start of the next cycle
    task automatic fetch_word(input logic [31:0] w);
        instr_in   = w;
        imem_ready = 1'b1;
        #1;
        check("fetch_state", 64'(state), 64'd0);
        check("fetch_imem_req", 64'(imem_req), 64'd1);
        check("fetch_pc_write", 64'(pc_write), 64'd1);
        check("fetch_pc_src", 64'(pc_src), 64'd0);
        step();
        imem_ready = 1'b0;
        #1;
        check("decode_state", 64'(state), 64'd1);
        check("decode_ir", 64'(ir), 64'(w));
        check("decode_pc_write", 64'(pc_write), 64'd0);
        check("decode_imem_req", 64'(imem_req), 64'd0);
        step();
    endtask

    task automatic run_add();
        fetch_word(32'h002081B3);
        #1;
        check("add_ex_state", 64'(state), 64'd2);
        check("add_ex_alu_op", 64'(alu_op), 64'd2);
        check("add_ex_alu_src_b", 64'(alu_src_b), 64'd0);
        check("add_ex_pc_write", 64'(pc_write), 64'd0);
        check("add_ex_instr_done", 64'(instr_done), 64'd0);
        step();
        #1;
        check("add_wb_state", 64'(state), 64'd4);
        check("add_wb_reg_write", 64'(reg_write), 64'd1);
        check("add_wb_sel", 64'(wb_sel), 64'd0);
        check("add_wb_instr_done", 64'(instr_done), 64'd1);
        check("add_wb_pc_write", 64'(pc_write), 64'd0);
        step();
        #1;
        check("add_back_fetch", 64'(state), 64'd0);
        check("add_done_low", 64'(instr_done), 64'd0);
    endtask

    task automatic run_branch(input string tag, input logic [31:0] w, input logic z, input logic exp_pcw);
        fetch_word(w);
        zero = z;
        #1;
        check({tag, "_state"}, 64'(state), 64'd2);
        check({tag, "_alu_op"}, 64'(alu_op), 64'd1);
        check({tag, "_pc_src"}, 64'(pc_src), 64'd1);
        check({tag, "_pc_write"}, 64'(pc_write), 64'(exp_pcw));
        check({tag, "_instr_done"}, 64'(instr_done), 64'd1);
        step();
        zero = 1'b0;
        #1;
        check({tag, "_next"}, 64'(state), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        instr_in   = 32'hFFFFFFFF;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        zero       = 1'b0;
        step();
        step();
        #1;
        check("rst_state", 64'(state), 64'd0);
        check("rst_ir", 64'(ir), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_err", 64'(err_code), 64'd0);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_pc_write", 64'(pc_write), 64'd0);
        imem_ready = 1'b0;
        reset      = 1'b1;
        #1;

        run_add();

        // lw with dmem_ready arriving on the 4th MEM cycle
        fetch_word(32'h0000A183);
        #1;
        check("lw_ex_alu_src_b", 64'(alu_src_b), 64'd1);
        check("lw_ex_alu_op", 64'(alu_op), 64'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lw_mem_wait_state", 64'(state), 64'd3);
            check("lw_mem_wait_req", 64'(dmem_req), 64'd1);
            check("lw_mem_wait_we", 64'(mem_write), 64'd0);
            step();
        end
        dmem_ready = 1'b1;
        #1;
        check("lw_mem_ready_state", 64'(state), 64'd3);
        check("lw_mem_ready_req", 64'(dmem_req), 64'd1);
        step();
        dmem_ready = 1'b0;
        #1;
        check("lw_wb_state", 64'(state), 64'd4);
        check("lw_wb_sel", 64'(wb_sel), 64'd1);
        check("lw_wb_reg_write", 64'(reg_write), 64'd1);
        check("lw_wb_instr_done", 64'(instr_done), 64'd1);
        step();
        #1;
        check("lw_back_fetch", 64'(state), 64'd0);

        // sw with zero-wait dmem
        fetch_word(32'h0030A023);
        step();
        dmem_ready = 1'b1;
        #1;
        check("sw_mem_state", 64'(state), 64'd3);
        check("sw_mem_write", 64'(mem_write), 64'd1);
        check("sw_dmem_req", 64'(dmem_req), 64'd1);
        check("sw_instr_done", 64'(instr_done), 64'd1);
        check("sw_reg_write", 64'(reg_write), 64'd0);
        step();
        dmem_ready = 1'b0;
        #1;
        check("sw_back_fetch", 64'(state), 64'd0);

        run_branch("beq_z1", 32'h00208463, 1'b1, 1'b1);
        run_branch("beq_z0", 32'h00208463, 1'b0, 1'b0);
        run_branch("bne_z1", 32'h00209463, 1'b1, 1'b0);
        run_branch("bne_z0", 32'h00209463, 1'b0, 1'b1);

        // dmem timeout on a store: 16 MEM cycles without ready
        fetch_word(32'h0030A023);
        step();
        repeat (15) step();
        #1;
        check("dmem_to_still_mem", 64'(state), 64'd3);
        step();
        #1;
        check("dmem_to_state", 64'(state), 64'd5);
        check("dmem_to_err", 64'(err_code), 64'd3);
        check("dmem_to_halted", 64'(halted), 64'd1);

        // illegal opcode
        do_reset();
        fetch_word(32'hFFFFFFFF);
        #1;
        check("ill_state", 64'(state), 64'd5);
        check("ill_err", 64'(err_code), 64'd1);
        check("ill_halted", 64'(halted), 64'd1);
        check("ill_imem_req", 64'(imem_req), 64'd0);
        imem_ready = 1'b1;
        step();
        step();
        #1;
        check("ill_sticky_state", 64'(state), 64'd5);
        check("ill_sticky_err", 64'(err_code), 64'd1);
        check("ill_sticky_imem_req", 64'(imem_req), 64'd0);
        imem_ready = 1'b0;
        reset      = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("ill_rst_state", 64'(state), 64'd0);
        check("ill_rst_halted", 64'(halted), 64'd0);
        check("ill_rst_err", 64'(err_code), 64'd0);

        // imem timeout: 15 waits tolerated, 16th cycle without ready errors
        repeat (15) step();
        #1;
        check("imem_to_still_fetch", 64'(state), 64'd0);
        check("imem_to_req", 64'(imem_req), 64'd1);
        step();
        #1;
        check("imem_to_state", 64'(state), 64'd5);
        check("imem_to_err", 64'(err_code), 64'd2);

        // reset asserted mid-MEM
        do_reset();
        fetch_word(32'h0000A183);
        step();
        #1;
        check("midmem_state", 64'(state), 64'd3);
        check("midmem_req", 64'(dmem_req), 64'd1);
        reset = 1'b0;
        #1;
        check("midmem_req_gated", 64'(dmem_req), 64'd0);
        step();
        reset = 1'b1;
        #1;
        check("midmem_rst_state", 64'(state), 64'd0);

`ifdef RETIRE_COUNT_EN
        do_reset();
        check("instret_rst", instret, 64'd0);
        run_add();
        run_add();
        run_add();
        check("instret_three", instret, 64'd3);
        fetch_word(32'hFFFFFFFF);
        #1;
        check("instret_err_state", 64'(state), 64'd5);
        step();
        #1;
        check("instret_hold", instret, 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
